// File: rtl/cc_pkg.sv
// Shared definitions for the condition-code unit and its neighbours:
// Y86 condition function codes, ALU op encodings, FSM states and the flag bundle.
package cc_pkg;

    localparam logic [3:0] C_YES = 4'd0;
    localparam logic [3:0] C_LE  = 4'd1;
    localparam logic [3:0] C_L   = 4'd2;
    localparam logic [3:0] C_E   = 4'd3;
    localparam logic [3:0] C_NE  = 4'd4;
    localparam logic [3:0] C_GE  = 4'd5;
    localparam logic [3:0] C_G   = 4'd6;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_t;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } flags_t;

    // Architectural flags after reset: the machine looks as if it produced a zero.
    localparam flags_t FLAGS_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/cc_if.sv
// Bundle of ALU-result, condition-query and flag-status signals around cc_unit.
// The master side (pipeline) drives results and queries; the slave side (cc_unit)
// returns the condition answer and the architectural flags.
interface cc_if #(
    parameter int W     = 64,
    parameter int CNT_W = 16
);
    logic             res_valid;
    logic [W-1:0]     alu_ans;
    logic             alu_ovf;
    logic [1:0]       alu_sel;
    logic             set_cc;
    logic             exc;
    logic             cnd_req;
    logic [3:0]       cnd_ifun;
    logic             cnd;
    logic             cnd_valid;
    logic             cnd_err;
    logic             zf;
    logic             sf;
    logic             of;
    logic             frozen;
    logic [CNT_W-1:0] upd_cnt;

    modport master (
        output res_valid, alu_ans, alu_ovf, alu_sel, set_cc, exc, cnd_req, cnd_ifun,
        input  cnd, cnd_valid, cnd_err, zf, sf, of, frozen, upd_cnt
    );

    modport slave (
        input  res_valid, alu_ans, alu_ovf, alu_sel, set_cc, exc, cnd_req, cnd_ifun,
        output cnd, cnd_valid, cnd_err, zf, sf, of, frozen, upd_cnt
    );
endinterface

// File: rtl/cond_eval.sv
// Purely combinational Y86 condition evaluator; also shared with fetch/PC-select.
// Codes 7..15 are not conditions: they answer false and raise err.
module cond_eval
    import cc_pkg::*;
(
    input  flags_t     flags,
    input  logic [3:0] ifun,
    output logic       cnd,
    output logic       err
);
    logic lt;

    // Decode the condition code against the supplied flags.
    always_comb begin
        lt  = flags.sf ^ flags.of;
        cnd = 1'b0;
        err = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | flags.zf;
            C_L:     cnd = lt;
            C_E:     cnd = flags.zf;
            C_NE:    cnd = ~flags.zf;
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~flags.zf;
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/cc_unit.sv
// Condition-code unit: holds ZF/SF/OF, locks them once a later stage reports an
// exception, answers condition queries one cycle later and counts flag updates.
module cc_unit #(
    parameter int W     = 64,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    cc_if.slave bus
);
    import cc_pkg::*;

    state_t           state;
    state_t           state_next;
    flags_t           flags;
    flags_t           flags_new;
    flags_t           flags_eval;
    logic             accept;
    logic             eval_cnd;
    logic             eval_err;
    logic [CNT_W-1:0] cnt;
    logic             cnd_q;
    logic             cnd_valid_q;
    logic             cnd_err_q;

    // State register; reset always returns to RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // Next state: an exception freezes the flags until the next reset.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (bus.exc) state_next = FROZEN;
            FROZEN:  state_next = FROZEN;
            default: state_next = state;
        endcase
    end

    // FSM outputs: frozen indicator and the update-accept qualifier.
    always_comb begin
        bus.frozen = (state == FROZEN);
        accept     = bus.res_valid && bus.set_cc && !bus.exc && (state == RUN);
    end

    // Candidate flags from the ALU result; logical ops never overflow. Queries see
    // the candidate in the cycle it is accepted so a compare can feed a branch directly.
    always_comb begin
        flags_new.zf = (bus.alu_ans == '0);
        flags_new.sf = bus.alu_ans[W-1];
        flags_new.of = ((bus.alu_sel == ALU_ADD) || (bus.alu_sel == ALU_SUB)) ? bus.alu_ovf : 1'b0;
        flags_eval   = accept ? flags_new : flags;
    end

    cond_eval u_cond_eval (
        .flags (flags_eval),
        .ifun  (bus.cnd_ifun),
        .cnd   (eval_cnd),
        .err   (eval_err)
    );

    // Flag register and saturating update counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= FLAGS_RESET;
            cnt   <= '0;
        end else if (accept) begin
            flags <= flags_new;
            if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
        end
    end

    // Query response register; answer and error hold between queries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnd_q       <= 1'b0;
            cnd_valid_q <= 1'b0;
            cnd_err_q   <= 1'b0;
        end else begin
            cnd_valid_q <= bus.cnd_req;
            if (bus.cnd_req) begin
                cnd_q     <= eval_cnd;
                cnd_err_q <= eval_err;
            end
        end
    end

    assign bus.cnd       = cnd_q;
    assign bus.cnd_valid = cnd_valid_q;
    assign bus.cnd_err   = cnd_err_q;
    assign bus.zf        = flags.zf;
    assign bus.sf        = flags.sf;
    assign bus.of        = flags.of;
    assign bus.upd_cnt   = cnt;
endmodule
